// File: rtl/line_feeder_pkg.sv
// Shared types and width helpers for the line feeder that sits in front of
// imageProcessTop.
package line_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        WAIT  = 3'd2,
        LINE  = 3'd3,
        PWAIT = 3'd4,
        PAD   = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Width of an index running 0..n-1.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a count running 0..n.
    function automatic int cntWidth(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/line_feeder_fifo.sv
// Small synchronous first-word-fall-through FIFO; the head entry is always
// visible on dout while the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // The extra top pointer bit tells a full ring from an empty one.
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign dout  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) wrPtr <= wrPtr + 1'b1;
            if (pop && !empty) rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/line_feeder.sv
// Buffers a raster grey pixel stream and hands it to imageProcessTop one line
// per interrupt, followed by zero padding lines and a done pulse.
module line_feeder
    import line_feeder_pkg::*;
#(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       axi_clk,
    input  logic       axi_reset,
    input  logic       i_start,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       i_intr,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] dbgState
);

    localparam int PIX_W  = idxWidth(IMG_W);
    localparam int ACC_W  = cntWidth(IMG_W * IMG_H);
    localparam int LINE_W = cntWidth(IMG_H);
    localparam int PAD_W  = cntWidth(PAD_LINES);
    localparam int FILL_W = cntWidth(FIFO_DEPTH);

    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_W - 1);
    localparam logic [ACC_W-1:0]  ACC_TOTAL  = ACC_W'(IMG_W * IMG_H);
    localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_LINES - 1);
    localparam logic [LINE_W-1:0] LINE_ALL   = LINE_W'(IMG_H);
    localparam logic [PAD_W-1:0]  PAD_LAST   = PAD_W'(PAD_LINES - 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(FIFO_DEPTH);

    state_t state, stateNext;

    logic [PIX_W-1:0]  pixCnt;
    logic [LINE_W-1:0] lineCnt;
    logic [PAD_W-1:0]  padCnt;
    logic [ACC_W-1:0]  accCnt, accNext;
    logic [FILL_W-1:0] fillCnt, fillNext;
    logic              intrQ, intrPending, intrEdge, consume;
    logic              issuing, padBeat, popEn, pushEn, beat, lineEnd;
    logic [7:0]        fifoDout;
    logic              fifoFull, fifoEmpty;

    // Source handshake: a pixel moves on a clock edge where s_valid and s_ready
    // are both high; s_ready is registered from next-cycle occupancy so it never
    // promises space the FIFO will not have.
    assign pushEn   = s_valid && s_ready && !fifoFull;
    assign issuing  = (state == PRIME) || (state == LINE);
    assign padBeat  = (state == PAD);
    assign popEn    = issuing && !fifoEmpty;
    assign beat     = popEn || padBeat;
    assign lineEnd  = beat && (pixCnt == PIX_LAST);
    assign intrEdge = i_intr && !intrQ;
    assign fillNext = fillCnt + FILL_W'(pushEn) - FILL_W'(popEn);
    assign accNext  = (state == IDLE) ? '0 : accCnt + ACC_W'(pushEn);
    assign dbgState = state;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) fifo (
        .clk  (axi_clk),
        .rst  (axi_reset),
        .push (pushEn),
        .pop  (popEn),
        .din  (s_data),
        .dout (fifoDout),
        .full (fifoFull),
        .empty(fifoEmpty)
    );

    always_comb begin
        stateNext = state;
        consume   = 1'b0;
        case (state)
            IDLE:  if (i_start) stateNext = PRIME;
            PRIME: if (lineEnd && lineCnt == PRIME_LAST) stateNext = WAIT;
            // Once all source lines are out, the pending slot is left for PWAIT.
            WAIT: begin
                if (intrPending) begin
                    if (lineCnt == LINE_ALL) begin
                        stateNext = PWAIT;
                    end else begin
                        stateNext = LINE;
                        consume   = 1'b1;
                    end
                end
            end
            LINE:  if (lineEnd) stateNext = WAIT;
            PWAIT: begin
                if (intrPending) begin
                    stateNext = PAD;
                    consume   = 1'b1;
                end
            end
            PAD:   if (lineEnd) stateNext = (padCnt == PAD_LAST) ? DONE : PWAIT;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) state <= IDLE;
        else           state <= stateNext;
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            pixCnt       <= '0;
            lineCnt      <= '0;
            padCnt       <= '0;
            accCnt       <= '0;
            fillCnt      <= '0;
            intrQ        <= 1'b0;
            intrPending  <= 1'b0;
            s_ready      <= 1'b0;
            o_data_valid <= 1'b0;
            o_data       <= 8'd0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            intrQ   <= i_intr;
            accCnt  <= accNext;
            fillCnt <= fillNext;
            if (state == IDLE) begin
                pixCnt      <= '0;
                lineCnt     <= '0;
                padCnt      <= '0;
                intrPending <= 1'b0;
            end else begin
                if (beat) pixCnt <= lineEnd ? '0 : pixCnt + 1'b1;
                if (lineEnd && issuing) lineCnt <= lineCnt + 1'b1;
                if (lineEnd && padBeat) padCnt <= padCnt + 1'b1;
                // A fresh edge wins over consumption so a coincident slot survives.
                intrPending <= intrEdge || (intrPending && !consume);
            end
            s_ready      <= (stateNext != IDLE) && (fillNext < FILL_MAX) && (accNext < ACC_TOTAL);
            o_data_valid <= beat;
            o_data       <= popEn ? fifoDout : 8'd0;
            o_busy       <= (stateNext != IDLE);
            o_done       <= (state == DONE);
        end
    end

    dropIntr: assert property (@(posedge axi_clk) disable iff (axi_reset)
        !((state != IDLE) && intrEdge && intrPending && !consume))
        else $error("line_feeder: intr edge dropped while one is already pending");

endmodule
